krz_uart_rx: RTL and testbench

KRZ_UART_RX -- requirements
Module: krz_uart_rx

---
 rtl/krz_uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_krz_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/krz_uart_rx.sv
// krz_uart_rx: 8N1 UART receiver with 16x oversampling and a small receive FIFO.
//
// Ports
//   clk       : sole clock, rising edge
//   rstz      : asynchronous active-low reset
//   rx        : asynchronous serial input, idle high, LSB first
//   rx_data   : byte at the FIFO head (0 when empty after reset)
//   rx_valid  : FIFO non-empty
//   rx_ready  : consumer pop; a byte leaves when rx_valid && rx_ready at a clk edge
//   frame_err : one-cycle pulse when a stop bit samples low
//   overrun   : one-cycle pulse when a completed byte is dropped on a full FIFO
//
// Handshake: rx_valid/rx_ready follow strict valid/ready semantics. rx_valid
// never depends on rx_ready, and rx_data is held stable while rx_valid is high
// and rx_ready is low; a transfer happens on every clk edge where both are high.
module krz_uart_rx #(
  parameter int CLK_DIV    = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int DIV_W = 12;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sub_q, sub_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic tick;
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign empty = (wr_q == rd_q);
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && rx_ready;
  assign tick  = (state_q != ST_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rxs_d       = rx_meta_q;
    div_d       = div_q;
    sub_d       = sub_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    wr_d        = wr_q;
    rd_d        = rd_q;
    mem_d       = mem_q;
    push        = 1'b0;

    // Oversample divider free-runs only while a frame is in progress.
    if (state_q != ST_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (!rxs_q) begin
          state_d = ST_START;
          sub_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sub_q == 4'd7) begin
            // Mid start bit: a high line means the falling edge was a glitch.
            state_d = rxs_q ? ST_IDLE : ST_DATA;
            sub_d   = '0;
            bit_d   = '0;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            shift_d = {rxs_q, shift_q[7:1]};
            sub_d   = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            sub_d = '0;
            if (rxs_q) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off through a break until the line returns high.
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    if (push && (!full || pop)) begin
      mem_d[wr_q[AW-1:0]] = shift_q;
      wr_d                = wr_q + PW'(1);
    end
    if (push && full && !pop) begin
      overrun_d = 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= ST_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      div_q       <= '0;
      sub_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      div_q       <= div_d;
      sub_q       <= sub_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mem_q       <= mem_d;
    end
  end

  assign rx_data   = mem_q[rd_q[AW-1:0]];
  assign rx_valid  = !empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_krz_uart_rx.sv
// tb_krz_uart_rx: directed bench for krz_uart_rx (CLK_DIV=4, 64 clk per bit,
// FIFO_DEPTH=4). Expected bytes go into exp_q when a frame is sent; a monitor
// pops and compares whenever a byte is transferred out of the DUT.
module tb_krz_uart_rx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rstz = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  krz_uart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rstz      (rstz),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pop_cnt = 0;
  int         last_pop_cyc = 0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rstz) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(mon_exp));
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; the first rx change lands just after the next clk edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (BIT_CLKS) @(posedge clk);
    #1 rx = 1'b1;
    wait_cycles(8);
  endtask

  task automatic drain(input string name);
    int n;
    rx_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    wait_cycles(3);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_valid_low"}, int'(rx_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  int start_cyc, fe0, ov0, pop0;

  initial begin
    rstz = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    wait_cycles(5);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rstz = 1'b1;
    wait_cycles(5);

    // Basic receive with latency bound.
    rx_ready = 1'b1;
    pop0 = pop_cnt;
    exp_q.push_back(8'hA5);
    start_cyc = cyc;
    send_byte(8'hA5, 1'b1);
    drain("basic");
    check("basic_pops", pop_cnt - pop0, 1);
    check("basic_latency_ok", int'((last_pop_cyc - start_cyc - 1) <= 10 * BIT_CLKS + 4), 1);

    // Glitch on the line, then a real byte.
    fe0 = fe_cnt;
    pop0 = pop_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(100);
    check("glitch_pops", pop_cnt - pop0, 0);
    check("glitch_frame_err", fe_cnt - fe0, 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    drain("after_glitch");
    check("after_glitch_pops", pop_cnt - pop0, 1);

    // Framing error: stop bit low, byte discarded, single-cycle pulse.
    fe0 = fe_cnt;
    pop0 = pop_cnt;
    send_byte(8'h55, 1'b0);
    wait_cycles(20);
    check("frame_err_cycles", fe_cnt - fe0, 1);
    check("frame_err_pops", pop_cnt - pop0, 0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    drain("after_frame_err");
    check("after_frame_err_pops", pop_cnt - pop0, 1);
    check("after_frame_err_fe", fe_cnt - fe0, 1);

    // Overrun: fifth byte dropped, first four intact.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    pop0 = pop_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    wait_cycles(5);
    check("overrun_pulses", ov_cnt - ov0, 1);
    check("overrun_valid_held", int'(rx_valid), 1);
    check("overrun_head", int'(rx_data), 8'h01);
    drain("overrun");
    check("overrun_pops", pop_cnt - pop0, 4);

    // Full FIFO with a pop on the exact push edge of the fifth byte.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    pop0 = pop_cnt;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    exp_q.push_back(8'h05);
    fork
      send_byte(8'h05, 1'b1);
      begin
        @(posedge clk);
        // Push edge is 611 clk after the first rx change (2 sync + 1 + 152 ticks*4).
        repeat (610) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    wait_cycles(5);
    check("simul_overrun", ov_cnt - ov0, 0);
    drain("simul");
    check("simul_pops", pop_cnt - pop0, 5);

    // Reset during data bit 4 with a byte already waiting in the FIFO.
    rx_ready = 1'b0;
    send_byte(8'h7E, 1'b1);
    check("pre_reset_valid", int'(rx_valid), 1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(posedge clk);
        #3 rstz = 1'b0;
        #1;
        check("midreset_rx_valid", int'(rx_valid), 0);
        check("midreset_rx_data", int'(rx_data), 0);
        check("midreset_frame_err", int'(frame_err), 0);
        check("midreset_overrun", int'(overrun), 0);
        repeat (4) @(posedge clk);
        #1 rstz = 1'b1;
      end
    join
    fe0 = fe_cnt;
    pop0 = pop_cnt;
    exp_q.push_back(8'h81);
    rx_ready = 1'b1;
    send_byte(8'h81, 1'b1);
    drain("after_reset");
    check("after_reset_pops", pop_cnt - pop0, 1);
    check("after_reset_fe", fe_cnt - fe0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
